asip_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the stepper-motor ASIP. It walks the program counter through instruction memory and drives the immediate extractor's `select` from the opcode. It captures the extracted immediate and issues accumulator-write, branch, step-pulse and delay control. It sits between the instruction ROM, the immediate extractor, the accumulator datapath and the step-pulse driver.

---
 rtl/asip_sequencer.sv | 158 +++++++++++++++
 tb/tb_asip_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/asip_sequencer.sv
// Fetch/decode/execute controller for the stepper-motor ASIP.
// Sequences pc, immediate capture, accumulator writes, step pulses and delays.
module asip_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] instr_in,
    input  logic [7:0] immediate,
    input  logic       acc_zero,
    input  logic       step_ready,
    output logic [7:0] pc,
    output logic [1:0] imm_sel,
    output logic [7:0] imm_value,
    output logic       acc_we,
    output logic       acc_src,
    output logic       step_valid,
    output logic       step_dir,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_STEP,
        S_DELAY,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_JMP  = 3'd3;
    localparam logic [2:0] OP_BNZ  = 3'd4;
    localparam logic [2:0] OP_STEP = 3'd5;
    localparam logic [2:0] OP_WAIT = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t     state, state_n;
    logic [7:0] ir, ir_n;
    logic [7:0] pc_n;
    logic [7:0] imm_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] op;
    logic [7:0] pc_inc;
    logic [7:0] pc_rel;

    assign op     = ir[7:5];
    assign pc_inc = pc + 8'd1;
    assign pc_rel = pc + imm_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= 8'd0;
            ir        <= 8'd0;
            imm_value <= 8'd0;
            cnt       <= 4'd0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            imm_value <= imm_n;
            cnt       <= cnt_n;
        end
    end

    always_comb begin
        imm_sel = 2'd3;
        case (op)
            OP_NOP:  imm_sel = 2'd3;
            OP_LDI:  imm_sel = 2'd1;
            OP_ADDI: imm_sel = 2'd2;
            OP_JMP:  imm_sel = 2'd2;
            OP_BNZ:  imm_sel = 2'd2;
            OP_STEP: imm_sel = 2'd0;
            OP_WAIT: imm_sel = 2'd1;
            OP_HALT: imm_sel = 2'd3;
            default: imm_sel = 2'd3;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        imm_n   = imm_value;
        cnt_n   = cnt;
        unique case (state)
            S_FETCH: begin
                if (run) begin
                    ir_n    = instr_in;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_n   = immediate;
                cnt_n   = immediate[3:0];
                state_n = S_EXEC;
            end
            S_EXEC: begin
                state_n = S_FETCH;
                pc_n    = pc_inc;
                case (op)
                    OP_JMP: pc_n = pc_rel;
                    OP_BNZ: begin
                        if (!acc_zero) pc_n = pc_rel;
                    end
                    OP_STEP: begin
                        if (cnt != 4'd0) begin
                            state_n = S_STEP;
                            pc_n    = pc;
                        end
                    end
                    OP_WAIT: begin
                        if (cnt != 4'd0) begin
                            state_n = S_DELAY;
                            pc_n    = pc;
                        end
                    end
                    OP_HALT: begin
                        state_n = S_HALT;
                        pc_n    = pc;
                    end
                    default: ;
                endcase
            end
            S_STEP: begin
                // Count only accepted pulses; request stays up while stalled.
                if (step_ready) begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        pc_n    = pc_inc;
                        state_n = S_FETCH;
                    end
                end
            end
            S_DELAY: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    pc_n    = pc_inc;
                    state_n = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_n = S_FETCH;
        endcase
    end

    assign acc_we     = (state == S_EXEC) &&
                        ((op == OP_LDI) || (op == OP_ADDI));
    assign acc_src    = (state == S_EXEC) && (op == OP_ADDI);
    assign step_valid = (state == S_STEP);
    assign step_dir   = ir[1];
    assign halted     = (state == S_HALT) ||
                        ((state == S_EXEC) && (op == OP_HALT));

endmodule

// File: tb/tb_asip_sequencer.sv
// Directed bench for asip_sequencer with a ROM and immediate-extractor model.
// Table-driven program trace plus hand-written multi-cycle sequences.
module tb_asip_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] instr_in;
    logic [7:0] immediate;
    logic       acc_zero;
    logic       step_ready;
    logic [7:0] pc;
    logic [1:0] imm_sel;
    logic [7:0] imm_value;
    logic       acc_we;
    logic       acc_src;
    logic       step_valid;
    logic       step_dir;
    logic       halted;

    logic [7:0] rom [256];

    int checks = 0;
    int errors = 0;

    asip_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .instr_in   (instr_in),
        .immediate  (immediate),
        .acc_zero   (acc_zero),
        .step_ready (step_ready),
        .pc         (pc),
        .imm_sel    (imm_sel),
        .imm_value  (imm_value),
        .acc_we     (acc_we),
        .acc_src    (acc_src),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ext(input logic [1:0] s,
                                       input logic [7:0] w);
        case (s)
            2'd0:    ext = {5'd0, w[4:2]};
            2'd1:    ext = {3'd0, w[4:0]};
            2'd2:    ext = {{3{w[4]}}, w[4:0]};
            default: ext = 8'd0;
        endcase
    endfunction

    always_comb instr_in  = rom[pc];
    always_comb immediate = ext(imm_sel, rom[pc]);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        run        = 1'b1;
        step_ready = 1'b0;
        acc_zero   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       run;
        logic [7:0] pc;
        logic [1:0] sel;
        logic       we;
        logic       src;
        logic [7:0] imm;
        logic       halt;
    } vec_t;

    vec_t vt [12];
    int   hs;
    int   cyc;
    int   seen_valid;

    initial begin
        vt[0]  = '{1'b1, 8'd0, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b1, 8'd0, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[2]  = '{1'b1, 8'd0, 2'd1, 1'b1, 1'b0, 8'h0A, 1'b0};
        vt[3]  = '{1'b1, 8'd1, 2'd1, 1'b0, 1'b0, 8'h0A, 1'b0};
        vt[4]  = '{1'b1, 8'd1, 2'd2, 1'b0, 1'b0, 8'h0A, 1'b0};
        vt[5]  = '{1'b1, 8'd1, 2'd2, 1'b1, 1'b1, 8'hFF, 1'b0};
        vt[6]  = '{1'b1, 8'd2, 2'd2, 1'b0, 1'b0, 8'hFF, 1'b0};
        vt[7]  = '{1'b1, 8'd2, 2'd3, 1'b0, 1'b0, 8'hFF, 1'b0};
        vt[8]  = '{1'b1, 8'd2, 2'd3, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[9]  = '{1'b1, 8'd2, 2'd3, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[10] = '{1'b0, 8'd2, 2'd3, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[11] = '{1'b1, 8'd2, 2'd3, 1'b0, 1'b0, 8'h00, 1'b1};

        // LDI / ADDI / HALT program trace, cycle 1 = first FETCH
        rom_clear();
        rom[0] = 8'h2A;
        rom[1] = 8'h5F;
        rom[2] = 8'hE0;
        do_reset();
        chk("rst_step_valid", step_valid, 0);
        chk("rst_step_dir", step_dir, 0);
        chk("rst_acc_src", acc_src, 0);
        for (int i = 0; i < 12; i++) begin
            run = vt[i].run;
            chk($sformatf("c%0d_pc", i + 1), pc, vt[i].pc);
            chk($sformatf("c%0d_sel", i + 1), imm_sel, vt[i].sel);
            chk($sformatf("c%0d_we", i + 1), acc_we, vt[i].we);
            chk($sformatf("c%0d_src", i + 1), acc_src, vt[i].src);
            chk($sformatf("c%0d_imm", i + 1), imm_value, vt[i].imm);
            chk($sformatf("c%0d_halt", i + 1), halted, vt[i].halt);
            tick();
        end

        // BNZ at 0x05 with offset -2
        for (int z = 0; z < 2; z++) begin
            rom_clear();
            rom[5] = 8'h9E;
            do_reset();
            acc_zero = (z == 1);
            repeat (15) tick();
            chk("bnz_at5", pc, 8'h05);
            repeat (3) tick();
            chk(z == 0 ? "bnz_taken" : "bnz_fall", pc,
                z == 0 ? 8'h03 : 8'h06);
        end

        // JMP -2 to 0xFE, then JMP +3 wraps to 0x01
        rom_clear();
        rom[0]     = 8'h7E;
        rom[8'hFE] = 8'h63;
        do_reset();
        repeat (3) tick();
        chk("jmp_back", pc, 8'hFE);
        repeat (3) tick();
        chk("jmp_wrap", pc, 8'h01);

        // STEP N=4 dir 1, ready low for two cycles
        rom_clear();
        rom[0] = 8'hB2;
        rom[1] = 8'hE0;
        do_reset();
        repeat (3) tick();
        hs  = 0;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            step_ready = (k >= 2);
            if (k < 2) chk("step_held", step_valid, 1);
            if (!step_valid) break;
            chk("step_dir", step_dir, 1);
            if (step_ready) hs++;
            cyc++;
            tick();
        end
        chk("step_pulses", hs, 4);
        chk("step_cycles", cyc, 6);
        chk("step_pc", pc, 8'h01);

        // WAIT 5, WAIT 0, STEP 0: cycles until pc advances
        for (int t = 0; t < 3; t++) begin
            rom_clear();
            rom[0] = (t == 0) ? 8'hC5 : (t == 1) ? 8'hC0 : 8'hA0;
            rom[1] = 8'hE0;
            do_reset();
            step_ready = 1'b1;
            cyc        = 1;
            seen_valid = 0;
            while (pc == 8'h00 && cyc < 50) begin
                if (step_valid) seen_valid++;
                tick();
                cyc++;
            end
            chk($sformatf("wait_len_%0d", t), cyc, (t == 0) ? 9 : 4);
            chk($sformatf("no_step_%0d", t), seen_valid, 0);
        end

        // Reset in the second STEP cycle, then run=0 stall
        rom_clear();
        rom[0] = 8'hB2;
        do_reset();
        repeat (4) tick();
        chk("mid_step_valid", step_valid, 1);
        reset = 1'b1;
        tick();
        chk("rst_mid_valid", step_valid, 0);
        chk("rst_mid_pc", pc, 8'h00);
        chk("rst_mid_sel", imm_sel, 3);
        reset = 1'b0;
        run   = 1'b0;
        repeat (5) tick();
        chk("stall_pc", pc, 8'h00);
        chk("stall_sel", imm_sel, 3);
        chk("stall_valid", step_valid, 0);
        run = 1'b1;
        repeat (3) tick();
        chk("resume_step", step_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
